nibble_bus_bridge: RTL

NIBBLE_BUS_BRIDGE -- requirements
Module: nibble_bus_bridge

---
 rtl/nibble_bus_pkg.sv | 16 +
 rtl/nibble_bus_arbiter.sv | 25 ++
 rtl/nibble_bus_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/nibble_bus_pkg.sv
// nibble_bus_pkg: shared FSM states, header layout and field-beat helper for the nibble bus bridge
package nibble_bus_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_ADR,
      ST_DAT,
      ST_RSP,
      ST_ACK
   } state_e;
   localparam int HDR_WE_BIT = 0;
   localparam int HDR_CH_LSB = 1;
   function automatic int beats(input int field_w, input int nib_w);
      return field_w / nib_w;
   endfunction
endpackage

// File: rtl/nibble_bus_arbiter.sv
// nibble_bus_arbiter: round-robin pick of the first requester at or after ptr
module nibble_bus_arbiter
   import nibble_bus_pkg::*;
#(
   parameter int NCH  = 2,
   parameter int CH_W = 1
) (
   input  logic [NCH-1:0]  req,
   input  logic [CH_W-1:0] ptr,
   output logic [NCH-1:0]  gnt,
   output logic [CH_W-1:0] idx
);
   always_comb begin
      gnt = '0;
      idx = '0;
      // scan from the farthest offset down so the nearest requester overwrites last
      for (int i = NCH - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % NCH]) begin
            gnt = '0;
            gnt[(int'(ptr) + i) % NCH] = 1'b1;
            idx = CH_W'((int'(ptr) + i) % NCH);
         end
      end
   end
endmodule

// File: rtl/nibble_bus_bridge.sv
// nibble_bus_bridge: multiplexes NCH CPU bus channels onto a strobed nibble-wide host link
module nibble_bus_bridge
   import nibble_bus_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int DATA_W = 32,
   parameter int ADR_W  = 16,
   parameter int NIB_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NCH-1:0]        req_cyc,
   input  logic [NCH-1:0]        req_we,
   input  logic [NCH*ADR_W-1:0]  req_adr,
   input  logic [NCH*DATA_W-1:0] req_dat,
   output logic [NCH*DATA_W-1:0] rsp_rdt,
   output logic [NCH-1:0]        rsp_ack,
   input  logic [NIB_W-1:0]      pin_in,
   input  logic                  pin_stb,
   output logic [NIB_W-1:0]      pin_out,
   output logic                  pin_frame,
   output logic                  pin_dir
);
   localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int ADR_BEATS = beats(ADR_W, NIB_W);
   localparam int DAT_BEATS = beats(DATA_W, NIB_W);
   localparam int MAX_BEATS = (ADR_BEATS > DAT_BEATS) ? ADR_BEATS : DAT_BEATS;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);
   localparam int HDR_CH_W  = NIB_W - HDR_CH_LSB;

   if (DATA_W % NIB_W != 0 || ADR_W % NIB_W != 0 || NIB_W < 2 || NCH < 1 || NCH > 2 ** (NIB_W - 1)) begin : g_bad_cfg
      $error("nibble_bus_bridge: illegal NCH/DATA_W/ADR_W/NIB_W combination");
   end

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CH_W-1:0]       ptr_q, ptr_d;
   logic [CH_W-1:0]       g_q, g_d;
   logic                  we_q, we_d;
   logic [ADR_W-1:0]      adr_q, adr_d;
   logic [DATA_W-1:0]     dat_q, dat_d;
   logic [DATA_W-1:0]     sh_q, sh_d;
   logic [NCH*DATA_W-1:0] rdt_q, rdt_d;
   logic [NCH-1:0]        arb_gnt;
   logic [CH_W-1:0]       arb_idx;
   logic                  last;
   logic [CNT_W-1:0]      cnt_inc;
   logic [DATA_W-1:0]     sh_nxt;
   logic [NIB_W-1:0]      hdr;

   nibble_bus_arbiter #(.NCH(NCH), .CH_W(CH_W)) u_arb (
      .req(req_cyc),
      .ptr(ptr_q),
      .gnt(arb_gnt),
      .idx(arb_idx)
   );

   assign last    = cnt_q == ((state_q == ST_ADR) ? CNT_W'(ADR_BEATS - 1) : CNT_W'(DAT_BEATS - 1));
   assign cnt_inc = last ? '0 : cnt_q + 1'b1;
   // read nibbles arrive LSB first, so each new beat enters at the top and shifts down
   assign sh_nxt  = (sh_q >> NIB_W) | (DATA_W'(pin_in) << (DATA_W - NIB_W));
   assign rsp_rdt = rdt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         g_q     <= '0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sh_q    <= '0;
         rdt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sh_q    <= sh_d;
         rdt_q   <= rdt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sh_d    = sh_q;
      rdt_d   = rdt_q;
      case (state_q)
         ST_IDLE: if (|req_cyc) begin
            state_d = ST_HDR;
            cnt_d   = '0;
            g_d     = arb_idx;
            we_d    = |(req_we & arb_gnt);
            adr_d   = req_adr[arb_idx*ADR_W +: ADR_W];
            dat_d   = req_dat[arb_idx*DATA_W +: DATA_W];
         end
         ST_HDR: if (pin_stb) state_d = ST_ADR;
         ST_ADR: if (pin_stb) begin
            cnt_d = cnt_inc;
            if (last) state_d = we_q ? ST_DAT : ST_RSP;
         end
         ST_DAT: if (pin_stb) begin
            cnt_d = cnt_inc;
            if (last) state_d = ST_ACK;
         end
         ST_RSP: if (pin_stb) begin
            cnt_d = cnt_inc;
            sh_d  = sh_nxt;
            if (last) begin
               state_d = ST_ACK;
               rdt_d[g_q*DATA_W +: DATA_W] = sh_nxt;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            ptr_d   = (g_q == CH_W'(NCH - 1)) ? '0 : g_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hdr = '0;
      hdr[HDR_WE_BIT] = we_q;
      hdr[NIB_W-1:HDR_CH_LSB] = HDR_CH_W'(g_q);
      pin_out   = (state_q == ST_HDR) ? hdr :
                  (state_q == ST_ADR) ? adr_q[cnt_q*NIB_W +: NIB_W] :
                  (state_q == ST_DAT) ? dat_q[cnt_q*NIB_W +: NIB_W] : '0;
      pin_frame = state_q inside {ST_HDR, ST_ADR, ST_DAT, ST_RSP};
      pin_dir   = state_q == ST_RSP;
      rsp_ack   = (state_q == ST_ACK) ? NCH'(1) << g_q : '0;
   end
endmodule
